// File: rtl/seg_scan_driver.sv
// seg_scan_driver: multiplexed 4-digit, 7-segment scan driver.
// Turns a one-hot scan phase from an upstream ring counter into active-low
// digit enables and hex-decoded segments. It also watches the phase stream
// for non-one-hot codes (err) and out-of-order steps (seq_err), and counts
// completed rotations.
// The display value is double-buffered. A load goes into a pending
// register, which is committed at the next frame boundary (phase == 0001),
// so the digits never change in the middle of a frame.
//
// Ports:
//   clk        rising-edge system clock
//   reset      synchronous, active-high reset
//   phase      one-hot scan phase; bit k selects digit k
//   data       display value; digit k is data[4k+3:4k]
//   load       capture data into the pending buffer
//   an         active-low digit enables (registered)
//   seg        active-low segments {g,f,e,d,c,b,a} (registered)
//   idx        binary index of the last valid phase (registered)
//   frame_done one-cycle pulse on an in-sequence 0100 -> 1000 step
//   rot_count  completed rotations, saturating at 255
//   err        sticky: a non-one-hot phase was seen
//   seq_err    sticky: a valid phase arrived out of order
module seg_scan_driver (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  phase,
    input  logic [15:0] data,
    input  logic        load,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic [1:0]  idx,
    output logic        frame_done,
    output logic [7:0]  rot_count,
    output logic        err,
    output logic        seq_err
);

    localparam int unsigned DIGITS  = 4;
    localparam int unsigned DIG_W   = 4;
    localparam int unsigned DATA_W  = DIGITS * DIG_W;
    localparam int unsigned IDX_W   = 2;
    localparam int unsigned SEG_W   = 7;
    localparam int unsigned CNT_W   = 8;

    localparam logic [SEG_W-1:0]  SEG_BLANK = 7'b1111111;
    localparam logic [DIGITS-1:0] AN_OFF    = 4'b1111;
    localparam logic [CNT_W-1:0]  CNT_MAX   = 8'hFF;

    // Hex to active-low gfedcba segments.
    function automatic logic [SEG_W-1:0] hex_decode(input logic [DIG_W-1:0] v);
        logic [SEG_W-1:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Display buffers and sequence history.
    logic [DATA_W-1:0] active;
    logic [DATA_W-1:0] pending;
    logic              pending_valid;
    logic              has_hist;
    logic [IDX_W-1:0]  hist_idx;

    // Combinational decode of the current sample.
    logic              phase_valid;
    logic [IDX_W-1:0]  phase_idx;
    logic              boundary;
    logic [DATA_W-1:0] active_next;
    logic [DIG_W-1:0]  digit;
    logic [IDX_W-1:0]  expect_idx;
    logic              out_of_seq;
    logic              done;

    // Classify the phase and work out which buffer feeds this frame.
    always_comb begin
        phase_valid = 1'b0;
        phase_idx   = '0;
        boundary    = 1'b0;
        active_next = active;
        digit       = '0;
        expect_idx  = '0;
        out_of_seq  = 1'b0;
        done        = 1'b0;

        case (phase)
            4'b0001: begin phase_valid = 1'b1; phase_idx = 2'd0; end
            4'b0010: begin phase_valid = 1'b1; phase_idx = 2'd1; end
            4'b0100: begin phase_valid = 1'b1; phase_idx = 2'd2; end
            4'b1000: begin phase_valid = 1'b1; phase_idx = 2'd3; end
            default: begin phase_valid = 1'b0; phase_idx = '0;   end
        endcase

        boundary = phase_valid && (phase_idx == 2'd0);

        // A load that lands on the boundary commits immediately; otherwise
        // any buffered value is committed, so digit 0 already shows it.
        if (boundary) begin
            if (load) begin
                active_next = data;
            end else if (pending_valid) begin
                active_next = pending;
            end
        end

        digit = active_next[{phase_idx, 2'b00} +: DIG_W];

        // Ring order is 0->1->2->3->0; the 2-bit add wraps naturally.
        expect_idx = hist_idx + IDX_W'(1);
        out_of_seq = phase_valid && has_hist && (phase_idx != expect_idx);
        done       = phase_valid && has_hist && (phase_idx == 2'd3) &&
                     (hist_idx == 2'd2);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            active        <= '0;
            pending       <= '0;
            pending_valid <= 1'b0;
            has_hist      <= 1'b0;
            hist_idx      <= '0;
            an            <= AN_OFF;
            seg           <= SEG_BLANK;
            idx           <= '0;
            frame_done    <= 1'b0;
            rot_count     <= '0;
            err           <= 1'b0;
            seq_err       <= 1'b0;
        end else begin
            active <= active_next;

            if (boundary) begin
                pending_valid <= 1'b0;
                if (load) begin
                    pending <= data;
                end
            end else if (load) begin
                pending       <= data;
                pending_valid <= 1'b1;
            end

            if (phase_valid) begin
                an       <= ~(DIGITS'(1) << phase_idx);
                seg      <= hex_decode(digit);
                idx      <= phase_idx;
                hist_idx <= phase_idx;
                has_hist <= 1'b1;
                if (out_of_seq) begin
                    seq_err <= 1'b1;
                end
            end else begin
                // Blank the display; idx and sequence history hold.
                an  <= AN_OFF;
                seg <= SEG_BLANK;
                err <= 1'b1;
            end

            frame_done <= done;
            if (done && (rot_count != CNT_MAX)) begin
                rot_count <= rot_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge SHALL occur here.
REQ-002 reset  input  1  synchronous, active-high reset; SHALL take effect only on a rising clk edge.
REQ-003 phase  input  4  one-hot scan phase from the upstream ring counter; bit k selects digit k.
REQ-004 data  input  16  display value; digit k SHALL be data[4k+3:4k].
REQ-005 load  input  1  SHALL capture data into the pending register when high.
REQ-006 an  output  4  active-low digit enables.
REQ-007 seg  output  7  active-low segments, order {g,f,e,d,c,b,a}.
REQ-008 idx  output  2  binary index of the current valid phase.
REQ-009 frame_done  output  1  single-cycle pulse on completed in-sequence rotation.
REQ-010 rot_count  output  8  count of completed rotations, saturating.
REQ-011 err  output  1  sticky flag for a non-one-hot phase.
REQ-012 seq_err  output  1  sticky flag for an out-of-order valid phase.

Function
REQ-013 All outputs SHALL be registered; outputs after edge n+1 SHALL reflect phase, load and data sampled at edge n (1-cycle latency).
REQ-014 Valid phase SHALL mean exactly one bit set: 0001, 0010, 0100 or 1000.
REQ-015 On valid phase bit k: an SHALL be all ones except an[k]=0, idx SHALL be k, and seg SHALL be the hex decode of active digit k.
REQ-016 On invalid phase (0000 or more than one bit set): an SHALL be 1111, seg SHALL be 7'b1111111, idx SHALL hold, err SHALL be set, and sequence history SHALL be unchanged.
REQ-017 Hex decode (gfedcba, active-low) SHALL be:
- 0=1000000, 1=1111001, 2=0100100, 3=0110000
- 4=0011001, 5=0010010, 6=0000010, 7=1111000
- 8=0000000, 9=0010000, A=0001000, b=0000011
- C=1000110, d=0100001, E=0000110, F=0001110
REQ-018 Expected order SHALL be 0001->0010->0100->1000->0001 (rotate left).
REQ-019 A valid phase that does not follow the previous valid phase in this order SHALL set seq_err, SHALL still be displayed normally, and SHALL become the new history.
REQ-020 The first valid phase after reset SHALL NOT be sequence-checked.
REQ-021 Double buffering: load=1 SHALL write data to pending and set pending_valid.
REQ-022 Frame boundary is a cycle with phase=0001; at a boundary, active SHALL be loaded from data if load=1, otherwise from pending if pending_valid=1, otherwise it SHALL hold. pending_valid SHALL clear at the boundary.
REQ-023 The digit-0 display at a boundary SHALL use the newly committed active value.
REQ-024 A load outside a boundary SHALL NOT change the digits of the current frame.
REQ-025 Back-to-back loads SHALL overwrite pending; the last one wins.
REQ-026 frame_done SHALL pulse for one cycle when phase=1000 is valid and in sequence, with the 0100 before it; the first phase after reset does not qualify.
REQ-027 rot_count SHALL increment on each frame_done and saturate at 255 (no wrap).
REQ-028 err and seq_err SHALL clear only on reset.

Reset
REQ-029 On reset:
- an=1111, seg=1111111, idx=00
- frame_done=0, rot_count=0, err=0, seq_err=0
- active=0, pending=0, pending_valid=0, sequence history empty
REQ-030 Reset SHALL take priority over load and phase in the same cycle; reset mid-frame SHALL abandon the frame with no frame_done.

Verification
REQ-031 Reset held 2 cycles with phase=0100 and load=1 -> all outputs at the REQ-029 values; rot_count=0.
REQ-032 load 16'h1234 with phase=0001, then 0010, 0100, 1000 -> the following cycles show:
- an=1110 / 1101 / 1011 / 0111
- seg=0011001 / 0110000 / 0100100 / 1111001
- frame_done=1 one cycle after the 1000 sample; rot_count=1
REQ-033 Active=16'h1234 and load 16'hABCD during phase 0100 -> phase 1000 shows digit 1; next frame shows d, C, b, A (0100001, 1000110, 0000011, 0001000).
REQ-034 phase=0011 for one cycle -> next cycle an=1111, seg=1111111, err=1; err stays 1 through later valid frames until reset.
REQ-035 Sequence 0001, 0100 -> seq_err=1, an=1011; no frame_done for that rotation.
REQ-036 260 clean rotations -> rot_count=255 and holds; reset asserted during phase 0010 -> next cycle all outputs at the REQ-029 values.
